// File: rtl/button_press_counter_pkg.sv
// button_press_counter_pkg: shared FSM encoding and default sizing for the button press counter.
package button_press_counter_pkg;
  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    PRESSED  = 2'd1,
    REPEAT   = 2'd2
  } state_e;
  localparam int DIV_BITS_DEF       = 16;
  localparam int STABLE_SAMPLES_DEF = 4;
endpackage

// File: rtl/button_press_counter_sample_tick.sv
// sample_tick: free-running prescaler emitting a one-cycle enable when the count is all-ones.
module sample_tick
  import button_press_counter_pkg::*;
#(
  parameter int DIV_BITS = DIV_BITS_DEF
) (
  input  logic CLK,
  input  logic RST,
  output logic tick
);
  logic [DIV_BITS-1:0] div_q;
  always_ff @(posedge CLK) begin
    if (RST) div_q <= '0;
    else     div_q <= div_q + 1'b1;
  end
  assign tick = &div_q;
endmodule

// File: rtl/button_press_counter.sv
// button_press_counter: synchronise, debounce and count presses of a bouncy button on LED.
// Define HOLD_REPEAT_EN to auto-repeat the count while the button stays held.
module button_press_counter
  import button_press_counter_pkg::*;
#(
  parameter int DIV_BITS       = DIV_BITS_DEF,
  parameter int STABLE_SAMPLES = STABLE_SAMPLES_DEF,
  parameter int CNT_W          = 8,
  parameter int REPEAT_DELAY   = 64,
  parameter int REPEAT_RATE    = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             BTN,
  output logic [CNT_W-1:0] LED,
  output logic             PRESS,
  output logic             BTN_STABLE
);
  localparam int AW = $clog2(STABLE_SAMPLES + 1);
  logic          tick;
  logic          sync1_q, sync2_q, stable_q, stable_d, press_q, flip, rise, fall;
  logic [AW-1:0] agree_q, agree_d, agree_n;
  logic [CNT_W-1:0] cnt_q;
  state_e        state_q;
`ifdef HOLD_REPEAT_EN
  localparam int RMAX = REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);
  logic [RW-1:0] rep_q;
  logic          rep_hit;
  assign rep_hit = rep_q == RW'((state_q == PRESSED ? REPEAT_DELAY : REPEAT_RATE) - 1);
`endif
  sample_tick #(.DIV_BITS(DIV_BITS)) u_tick (.CLK(CLK), .RST(RST), .tick(tick));
  // The FSM looks at the debounced level being written this cycle, so PRESS lands with BTN_STABLE.
  always_comb begin
    agree_n  = sync2_q == stable_q ? '0 : agree_q + 1'b1;
    flip     = tick && sync2_q != stable_q && agree_n == AW'(STABLE_SAMPLES);
    agree_d  = !tick ? agree_q : flip ? '0 : agree_n;
    stable_d = stable_q ^ flip;
    rise     = stable_d && !stable_q;
    fall     = !stable_d && stable_q;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      agree_q  <= '0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
      cnt_q    <= '0;
      state_q  <= RELEASED;
`ifdef HOLD_REPEAT_EN
      rep_q    <= '0;
`endif
    end else begin
      sync1_q  <= BTN;
      sync2_q  <= sync1_q;
      agree_q  <= agree_d;
      stable_q <= stable_d;
      press_q  <= 1'b0;
      if (state_q == RELEASED) begin
        if (rise) begin
          state_q <= PRESSED;
          press_q <= 1'b1;
          cnt_q   <= cnt_q + 1'b1;
        end
      end else if (fall) begin
        state_q <= RELEASED;
`ifdef HOLD_REPEAT_EN
        rep_q   <= '0;
      end else if (tick) begin
        rep_q <= rep_hit ? '0 : rep_q + 1'b1;
        if (rep_hit) begin
          state_q <= REPEAT;
          press_q <= 1'b1;
          cnt_q   <= cnt_q + 1'b1;
        end
`endif
      end
    end
  end
  assign LED        = cnt_q;
  assign PRESS      = press_q;
  assign BTN_STABLE = stable_q;
endmodule

// File: tb/tb_button_press_counter.sv
// tb_button_press_counter: directed self-checking bench for button_press_counter.
module tb_button_press_counter;
  logic       clk = 1'b0, rst = 1'b1, btn = 1'b0;
  logic [7:0] led;
  logic       press, stable;
  int n_cmp = 0, n_bad = 0;
  int presses = 0, run = 0, max_run = 0;
  button_press_counter #(
    .DIV_BITS(4), .STABLE_SAMPLES(3), .CNT_W(8), .REPEAT_DELAY(4), .REPEAT_RATE(2)
  ) dut (
    .CLK(clk), .RST(rst), .BTN(btn), .LED(led), .PRESS(press), .BTN_STABLE(stable)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1;
    if (press) begin
      presses = presses + 1;
      run = run + 1;
      if (run > max_run) max_run = run;
    end else run = 0;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
  endtask
  initial begin
    int base, lat, bad;
    bit found;
    @(negedge clk);
    do_reset();
    check("rst_led", led, 8'h00);
    check("rst_press", press, 1'b0);
    check("rst_stable", stable, 1'b0);
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (led != 8'h00 || press || stable) bad++;
    end
    check("idle_quiet", bad, 0);
    base = presses;
    btn = 1'b1;
    found = 0;
    lat = 0;
    for (int i = 0; i < 67 && !found; i++) begin
      @(negedge clk);
      lat++;
      if (press) found = 1;
    end
    check("press_latency", found, 1'b1);
    cyc(300 - lat);
    btn = 1'b0;
    found = 0;
    for (int i = 0; i < 67 && !found; i++) begin
      @(negedge clk);
      if (!stable) found = 1;
    end
    check("release_latency", found, 1'b1);
    cyc(80);
    check("clean_count", presses - base, 1);
    check("clean_led", led, 8'h01);
    do_reset();
    base = presses;
    for (int i = 0; i < 12; i++) begin
      btn = ~btn;
      cyc(5);
    end
    btn = 1'b1;
    cyc(200);
    check("bounce_count", presses - base, 1);
    check("bounce_led", led, 8'h01);
    btn = 1'b0;
    cyc(80);
    base = presses;
    bad = 0;
    btn = 1'b1;
    for (int i = 0; i < 120; i++) begin
      if (i == 20) btn = 1'b0;
      @(negedge clk);
      if (stable) bad++;
    end
    check("glitch_count", presses - base, 0);
    check("glitch_led", led, 8'h01);
    check("glitch_stable", bad, 0);
    do_reset();
    base = presses;
    for (int i = 0; i < 255; i++) begin
      btn = 1'b1;
      cyc(80);
      btn = 1'b0;
      cyc(80);
    end
    check("wrap_ff_led", led, 8'hFF);
    check("wrap_ff_count", presses - base, 255);
    base = presses;
    btn = 1'b1;
    cyc(80);
    btn = 1'b0;
    cyc(80);
    check("wrap_00_led", led, 8'h00);
    check("wrap_00_count", presses - base, 1);
    btn = 1'b1;
    cyc(100);
    check("hold_pre_led", led, 8'h01);
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    check("hold_rst_led", led, 8'h00);
    check("hold_rst_stable", stable, 1'b0);
    base = presses;
    cyc(80);
    check("hold_after_count", presses - base, 1);
    check("hold_after_led", led, 8'h01);
    btn = 1'b0;
    cyc(80);
    do_reset();
    btn = 1'b1;
    cyc(320);
    btn = 1'b0;
    cyc(100);
`ifdef HOLD_REPEAT_EN
    check("repeat_led", led, 8'h09);
`else
    check("repeat_led", led, 8'h01);
`endif
    check("press_width", max_run, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
